// File: rtl/rch_table_writer.sv
// ============================================================================
// Module   : rch_table_writer
// Brief    : Redundancy-checker write stage. It latches MT/ST entries, commits
//            them into flattened tables and queues freed destinations in a
//            free-list FIFO. Optional statistics: define RCH_TW_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rch_table_writer #(
  parameter int ITER_WIDTH    = 9,
  parameter int DIST_WIDTH    = 7,
  parameter int STEP_RANGE    = 128,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int FL_DEPTH      = 8
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic                                        tbl_clr,
  input  logic                                        rch_valid,
  input  logic                                        rch_done,
  input  logic [ITER_WIDTH-1:0]                       n_ch_it,
  input  logic [ITER_WIDTH-1:0]                       n_src_it,
  input  logic [ITER_WIDTH-1:0]                       n_dest_it,
  input  logic [STEP_RANGE-1:0]                       n_src_mt,
  input  logic [1:0]                                  n_src_st,
  input  logic [1:0]                                  n_dest_st,
  output logic                                        enable_wt,
  output logic                                        busy,
  output logic [MAX_LIFM_RSIZ*STEP_RANGE*STEP_RANGE-1:0] mt_buffer,
  output logic [MAX_LIFM_RSIZ*STEP_RANGE*2-1:0]       st_buffer,
  input  logic                                        fl_pop,
  output logic                                        fl_valid,
  output logic [ITER_WIDTH-1:0]                       fl_data,
  output logic                                        fl_ovf,
`ifdef RCH_TW_STATS_EN
  output logic [15:0]                                 wr_count,
  output logic [15:0]                                 drop_count,
`endif
  output logic                                        addr_err
);

  localparam int RW = ITER_WIDTH - DIST_WIDTH;
  localparam int AW = $clog2(FL_DEPTH);
  localparam logic [RW-1:0] C_ROWS    = RW'(MAX_LIFM_RSIZ);
  localparam logic [AW:0]   C_FL_FULL = (AW+1)'(FL_DEPTH);
  localparam logic [1:0]    C_ST_FREE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_CAPT   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  logic [ITER_WIDTH-1:0] r_ch_it, r_src_it, r_dest_it;
  logic [STEP_RANGE-1:0] r_src_mt;
  logic [1:0]            r_src_st, r_dest_st;

  logic [ITER_WIDTH-1:0] r_fl_mem [FL_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_fl_count;

  logic w_clr, w_commit, w_ch_ok, w_src_ok, w_dest_ok, w_dest_wr;
  logic w_push_req, w_full, w_pop, w_push, w_push_drop;

  assign w_clr       = tbl_clr && (r_state == S_IDLE || r_state == S_DONE);
  assign w_commit    = (r_state == S_COMMIT);
  assign w_ch_ok     = r_ch_it[ITER_WIDTH-1:DIST_WIDTH]   < C_ROWS;
  assign w_src_ok    = r_src_it[ITER_WIDTH-1:DIST_WIDTH]  < C_ROWS;
  assign w_dest_ok   = r_dest_it[ITER_WIDTH-1:DIST_WIDTH] < C_ROWS;
  assign w_dest_wr   = (r_dest_st == C_ST_FREE);
  assign w_push_req  = w_commit && w_dest_wr && w_dest_ok;
  assign w_full      = (r_fl_count == C_FL_FULL);
  assign w_pop       = fl_pop && (r_fl_count != '0) && !w_clr;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && w_full && !w_pop;
  assign fl_valid    = (r_fl_count != '0);

  // Handshake FSM; enable_wt and busy are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      enable_wt <= 1'b0;
      busy      <= 1'b0;
      r_ch_it   <= '0;
      r_src_it  <= '0;
      r_dest_it <= '0;
      r_src_mt  <= '0;
      r_src_st  <= '0;
      r_dest_st <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_ARM;
            enable_wt <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          if (rch_valid) begin
            r_ch_it   <= n_ch_it;
            r_src_it  <= n_src_it;
            r_dest_it <= n_dest_it;
            r_src_mt  <= n_src_mt;
            r_src_st  <= n_src_st;
            r_dest_st <= n_dest_st;
            r_state   <= S_CAPT;
            enable_wt <= 1'b0;
          end else if (rch_done) begin
            r_state   <= S_DONE;
            enable_wt <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_CAPT: begin
          if (!rch_valid) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_state   <= S_ARM;
          enable_wt <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          enable_wt <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Table commit: the dest ST write is applied last so it wins on aliasing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mt_buffer <= '0;
      st_buffer <= '0;
      addr_err  <= 1'b0;
    end else if (w_clr) begin
      mt_buffer <= '0;
      st_buffer <= '0;
      addr_err  <= 1'b0;
    end else if (w_commit) begin
      if (w_ch_ok)
        mt_buffer[int'(r_ch_it)*STEP_RANGE +: STEP_RANGE] <= r_src_mt;
      if (w_src_ok)
        st_buffer[int'(r_src_it)*2 +: 2] <= r_src_st;
      if (w_dest_wr && w_dest_ok)
        st_buffer[int'(r_dest_it)*2 +: 2] <= r_dest_st;
      if (!w_ch_ok || !w_src_ok || (w_dest_wr && !w_dest_ok))
        addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fl_mem[r_wr_ptr] <= r_dest_it;
  end

  // Free-list control; fl_data tracks the head so it is always registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fl_count <= '0;
      fl_data    <= '0;
      fl_ovf     <= 1'b0;
    end else if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fl_count <= '0;
      fl_data    <= '0;
      fl_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fl_count <= r_fl_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push_drop) fl_ovf <= 1'b1;
      if (w_pop) begin
        if (r_fl_count > (AW+1)'(1))
          fl_data <= r_fl_mem[r_rd_ptr + AW'(1)];
        else if (w_push)
          fl_data <= r_dest_it;
        else
          fl_data <= '0;
      end else if (r_fl_count == '0 && w_push) begin
        fl_data <= r_dest_it;
      end
    end
  end

`ifdef RCH_TW_STATS_EN
  logic [2:0]  w_drop_n;
  logic [16:0] w_drop_sum;

  assign w_drop_n = w_commit ? (3'(!w_ch_ok) + 3'(!w_src_ok) +
                                3'(w_dest_wr && !w_dest_ok) + 3'(w_push_drop))
                             : 3'd0;
  assign w_drop_sum = {1'b0, drop_count} + 17'(w_drop_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else if (w_clr) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if (w_commit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rch_table_writer.sv
// ============================================================================
// Module   : tb_rch_table_writer
// Brief    : Directed self-checking bench for rch_table_writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rch_table_writer;

  localparam int ITER_WIDTH = 9;
  localparam int STEP_RANGE = 128;
  localparam int ROWS       = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, tbl_clr = 1'b0, rch_valid = 1'b0, rch_done = 1'b0;
  logic [ITER_WIDTH-1:0] n_ch_it = '0, n_src_it = '0, n_dest_it = '0;
  logic [STEP_RANGE-1:0] n_src_mt = '0;
  logic [1:0] n_src_st = '0, n_dest_st = '0;
  logic enable_wt, busy, fl_valid, fl_ovf, addr_err, fl_pop = 1'b0;
  logic [ROWS*STEP_RANGE*STEP_RANGE-1:0] mt_buffer;
  logic [ROWS*STEP_RANGE*2-1:0] st_buffer;
  logic [ITER_WIDTH-1:0] fl_data;
`ifdef RCH_TW_STATS_EN
  logic [15:0] wr_count, drop_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rch_table_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tbl_clr(tbl_clr),
    .rch_valid(rch_valid), .rch_done(rch_done),
    .n_ch_it(n_ch_it), .n_src_it(n_src_it), .n_dest_it(n_dest_it),
    .n_src_mt(n_src_mt), .n_src_st(n_src_st), .n_dest_st(n_dest_st),
    .enable_wt(enable_wt), .busy(busy),
    .mt_buffer(mt_buffer), .st_buffer(st_buffer),
    .fl_pop(fl_pop), .fl_valid(fl_valid), .fl_data(fl_data), .fl_ovf(fl_ovf),
`ifdef RCH_TW_STATS_EN
    .wr_count(wr_count), .drop_count(drop_count),
`endif
    .addr_err(addr_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mt_at(input int idx);
    return mt_buffer[idx*STEP_RANGE +: STEP_RANGE];
  endfunction

  function automatic logic [1:0] st_at(input int idx);
    return st_buffer[idx*2 +: 2];
  endfunction

  task automatic wait_en(input string tag);
    for (int i = 0; i < 20 && !enable_wt; i++) @(negedge clk);
    chk(tag, enable_wt, 1'b1);
  endtask

  task automatic do_commit(input logic [8:0] ch, input logic [8:0] src, input logic [8:0] dest,
                           input logic [127:0] mt, input logic [1:0] sst, input logic [1:0] dst);
    wait_en("arm_en");
    n_ch_it = ch; n_src_it = src; n_dest_it = dest;
    n_src_mt = mt; n_src_st = sst; n_dest_st = dst;
    rch_valid = 1'b1;
    @(negedge clk);
    chk("capt_en_low", enable_wt, 1'b0);
    rch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pop_one();
    fl_pop = 1'b1;
    @(negedge clk);
    fl_pop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", enable_wt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flv", fl_valid, 1'b0);
    chk("rst_fld", fl_data, 9'h0);
    chk("rst_ovf", fl_ovf, 1'b0);
    chk("rst_aerr", addr_err, 1'b0);
    chk("rst_mt", |mt_buffer, 1'b0);
    chk("rst_st", |st_buffer, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic commit
    pulse_start();
    chk("arm_busy", busy, 1'b1);
    do_commit(9'h005, 9'h005, 9'h000, 128'h1, 2'b00, 2'b00);
    chk("t1_mt5", mt_at(5), 128'h1);
    chk("t1_st5", st_at(5), 2'b00);
    chk("t1_flv", fl_valid, 1'b0);
    chk("t1_en", enable_wt, 1'b1);

    // Redundant entry frees its destination
    do_commit(9'h010, 9'h003, 9'h083, 128'hABCD, 2'b10, 2'b01);
    chk("t2_st3", st_at(3), 2'b10);
    chk("t2_st131", st_at(131), 2'b01);
    chk("t2_mt16", mt_at(16), 128'hABCD);
    chk("t2_flv", fl_valid, 1'b1);
    chk("t2_fld", fl_data, 9'h083);
    pop_one();
    chk("t2_empty", fl_valid, 1'b0);

    // Overflow: nine pushes into an eight-deep free list
    for (int i = 0; i < 9; i++)
      do_commit(9'h020, 9'(i), 9'h100 + 9'(i), 128'(i), 2'b10, 2'b01);
    chk("t3_ovf", fl_ovf, 1'b1);
    chk("t3_flv", fl_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_pop%0d", i), fl_data, 9'h100 + 9'(i));
      pop_one();
    end
    chk("t3_empty", fl_valid, 1'b0);
    chk("t3_mt32", mt_at(32), 128'h8);

    // Out-of-range destination
    do_commit(9'h021, 9'h020, 9'h183, 128'h55, 2'b11, 2'b01);
    chk("t4_aerr", addr_err, 1'b1);
    chk("t4_nopush", fl_valid, 1'b0);
    chk("t4_st32", st_at(32), 2'b11);
    chk("t4_mt33", mt_at(33), 128'h55);

    // Aliased source/destination: destination write wins
    do_commit(9'h022, 9'h040, 9'h040, 128'h7, 2'b10, 2'b01);
    chk("t5_st64", st_at(64), 2'b01);
    chk("t5_fld", fl_data, 9'h040);

    // rch_done -> DONE, tables held, then clear and re-arm
    rch_done = 1'b1;
    @(negedge clk);
    rch_done = 1'b0;
    chk("t6_en", enable_wt, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_hold", mt_at(16), 128'hABCD);
    tbl_clr = 1'b1;
    @(negedge clk);
    tbl_clr = 1'b0;
    chk("t6_mt0", |mt_buffer, 1'b0);
    chk("t6_st0", |st_buffer, 1'b0);
    chk("t6_flv", fl_valid, 1'b0);
    chk("t6_ovf", fl_ovf, 1'b0);
    chk("t6_aerr", addr_err, 1'b0);
    pulse_start();
    chk("t6_rearm", enable_wt, 1'b1);

    // Reset during CAPT discards the latched entry
    n_ch_it = 9'h007; n_src_it = 9'h007; n_dest_it = 9'h000;
    n_src_mt = 128'hFF; n_src_st = 2'b11; n_dest_st = 2'b00;
    rch_valid = 1'b1;
    @(negedge clk);
    chk("t7_capt_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_en", enable_wt, 1'b0);
    chk("t7_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    rch_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_mt", |mt_buffer, 1'b0);
    chk("t7_st", |st_buffer, 1'b0);
    chk("t7_idle_en", enable_wt, 1'b0);
    chk("t7_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
